// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline sequencer: FSM state encoding and
// the per-register enable/flush bundle.
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } pipe_state_t;

   localparam int FLUSH_CNT_W = 3;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic memwb_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                     idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1,
                                     memwb_flush: 1'b0};

   // Whole pipe frozen; only MEM/WB drains a bubble.
   localparam pipe_ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                        idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0,
                                        memwb_flush: 1'b1};

   localparam pipe_ctl_t CTL_KILL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
                                      idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0,
                                      memwb_flush: 1'b1};

endpackage

// File: rtl/sat_counter_s.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter_s #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         q <= '0;
      else if (inc && (q != {W{1'b1}}))
         q <= q + W'(1);
   end

endmodule

// File: rtl/pipe_ctrl_s.sv
// Pipeline sequencer: prioritises mem stall > redirect > load-use and runs a
// memory watchdog. Perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_s
   import pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_WAIT_MAX = 15,
   parameter int CNT_W        = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hdu_stall,
   input  logic       ex_redirect,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       ifid_flush,
   output logic       idex_en,
   output logic       idex_flush,
   output logic       exmem_en,
   output logic       memwb_flush,
   output logic [1:0] state_o,
   output logic       timeout_err
`ifdef PIPE_CTRL_PERF_EN
  ,output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
`endif
);

   localparam int WAIT_LOG = $clog2(MEM_WAIT_MAX + 1);
   localparam int WAIT_W   = (WAIT_LOG < 1) ? 1 : WAIT_LOG;
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   // Compared against the pre-increment count, so the error fires on the
   // MEM_WAIT_MAX-th consecutive frozen cycle.
   localparam logic [WAIT_W-1:0] WAIT_LIM =
      WAIT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   pipe_state_t            state, state_n, mode;
   logic [FLUSH_CNT_W-1:0] fcnt, fcnt_n;
   logic                   resume, resume_n;
   logic                   frozen;
   logic                   mem_stall;
   logic [WAIT_W-1:0]      wcnt;
   pipe_ctl_t              ctl;

   assign mem_stall = mem_req & ~mem_ready;

   always_comb begin
      ctl      = CTL_RUN;
      state_n  = state;
      fcnt_n   = fcnt;
      resume_n = resume;
      frozen   = 1'b0;
      mode     = state;
      if (state == MEM_WAIT) begin
         if (!mem_ready) begin
            frozen = 1'b1;
            ctl    = CTL_FREEZE;
            if ((MEM_WAIT_MAX != 0) && (wcnt >= WAIT_LIM))
               state_n = ERR;
         end else begin
            mode = resume ? FLUSH : RUN;
         end
      end
      case (mode)
         RUN: begin
            state_n = RUN;
            if (mem_stall) begin
               frozen   = 1'b1;
               ctl      = CTL_FREEZE;
               state_n  = MEM_WAIT;
               resume_n = 1'b0;
            end else if (ex_redirect) begin
               ctl.ifid_flush = 1'b1;
               ctl.idex_flush = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_n = FLUSH;
                  fcnt_n  = FLUSH_RELOAD;
               end
            end else if (hdu_stall) begin
               ctl.pc_en      = 1'b0;
               ctl.ifid_en    = 1'b0;
               ctl.idex_flush = 1'b1;
            end
         end
         FLUSH: begin
            if (mem_stall) begin
               frozen   = 1'b1;
               ctl      = CTL_FREEZE;
               state_n  = MEM_WAIT;
               resume_n = 1'b1;
            end else begin
               ctl.ifid_flush = 1'b1;
               ctl.idex_flush = ex_redirect;
               if (ex_redirect) begin
                  state_n = FLUSH;
                  fcnt_n  = FLUSH_RELOAD;
               end else if (fcnt <= FLUSH_CNT_W'(1)) begin
                  state_n = RUN;
                  fcnt_n  = '0;
               end else begin
                  state_n = FLUSH;
                  fcnt_n  = fcnt - FLUSH_CNT_W'(1);
               end
            end
         end
         ERR:     ctl = CTL_KILL;
         default: ;
      endcase
      if (rst)
         ctl = CTL_KILL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         fcnt        <= '0;
         resume      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state  <= state_n;
         fcnt   <= fcnt_n;
         resume <= resume_n;
         if (state_n == ERR)
            timeout_err <= 1'b1;
      end
   end

   sat_counter_s #(.W(WAIT_W)) u_wait (
      .clk (clk),
      .rst (rst),
      .clr (~frozen),
      .inc (frozen),
      .q   (wcnt)
   );

   assign {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush} = ctl;
   assign state_o = state;

`ifdef PIPE_CTRL_PERF_EN
   // A load-use bubble is the only decode with pc held, no NOP in IF/ID and a bubble in ID/EX.
   logic lu_bubble;
   assign lu_bubble = ~ctl.pc_en & ~ctl.ifid_flush & ctl.idex_flush;

   sat_counter_s #(.W(CNT_W)) u_stall_cnt (
      .clk (clk), .rst (rst), .clr (1'b0), .inc (lu_bubble), .q (stall_cnt)
   );
   sat_counter_s #(.W(CNT_W)) u_flush_cnt (
      .clk (clk), .rst (rst), .clr (1'b0),
      .inc (ctl.ifid_flush & (state != ERR)), .q (flush_cnt)
   );
   sat_counter_s #(.W(CNT_W)) u_memwait_cnt (
      .clk (clk), .rst (rst), .clr (1'b0),
      .inc ((state == MEM_WAIT) & ~mem_ready), .q (memwait_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_ctrl_s.sv
// Scoreboard bench for pipe_ctrl_s (FLUSH_CYCLES=3, MEM_WAIT_MAX=15).
module tb_pipe_ctrl_s;
   import pipe_pkg::*;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
   localparam logic [6:0] C_RUN = 7'b1101010;
   localparam logic [6:0] C_RST = 7'b0010101;
   localparam logic [6:0] C_FRZ = 7'b0000001;
   localparam logic [6:0] C_LU  = 7'b0001110;
   localparam logic [6:0] C_RD  = 7'b1111110;
   localparam logic [6:0] C_FL  = 7'b1111010;

   logic clk = 1'b0, rst = 1'b1;
   logic hdu_stall = 1'b0, ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
   logic [1:0] state_o;
   logic timeout_err;
   logic [9:0] obs;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

   int nchk = 0, nerr = 0;
   typedef struct {logic [9:0] v; string nm;} exp_t;
   exp_t sb[$];
   exp_t cur;

   always #5 clk = ~clk;

   pipe_ctrl_s #(.FLUSH_CYCLES(3), .MEM_WAIT_MAX(15), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .hdu_stall(hdu_stall), .ex_redirect(ex_redirect),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .memwb_flush(memwb_flush), .state_o(state_o),
      .timeout_err(timeout_err)
`ifdef PIPE_CTRL_PERF_EN
     ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
`endif
   );

   assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush,
                 state_o, timeout_err};

   function automatic logic [9:0] ev(input logic [6:0] c, input logic [1:0] s, input logic t);
      return {c, s, t};
   endfunction

   // stim = {hdu_stall, ex_redirect, mem_req, mem_ready}; sample point is the next negedge
   task automatic drive(input logic [3:0] stim, input logic [9:0] e, input string nm);
      {hdu_stall, ex_redirect, mem_req, mem_ready} = stim;
      sb.push_back('{e, nm});
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(posedge clk); #1;
      drive(4'b0000, ev(C_RST, 2'd0, 1'b0), "reset_hold");
      cur = sb.pop_front(); nchk++;
      if (obs !== cur.v) begin nerr++; $display("FAIL %s: got %b want %b", cur.nm, obs, cur.v); end
`ifdef PIPE_CTRL_PERF_EN
      nchk++;
      if ({stall_cnt, flush_cnt, memwait_cnt} !== 96'd0) begin
         nerr++; $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, memwait_cnt);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      drive(4'b0000, ev(C_RUN, 2'd0, 1'b0), "reset_idle");
      cur = sb.pop_front(); nchk++;
      if (obs !== cur.v) begin nerr++; $display("FAIL %s: got %b want %b", cur.nm, obs, cur.v); end
      @(posedge clk); #1;
   endtask

   task automatic test_load_use;
      logic [3:0] stim [3];
      logic [9:0] e [3];
`ifdef PIPE_CTRL_PERF_EN
      logic [31:0] s0;
      s0 = stall_cnt;
`endif
      stim = '{4'b1000, 4'b0000, 4'b0000};
      e    = '{ev(C_LU, 0, 0), ev(C_RUN, 0, 0), ev(C_RUN, 0, 0)};
      for (int i = 0; i < 3; i++) begin
         drive(stim[i], e[i], "load_use");
         cur = sb.pop_front(); nchk++;
         if (obs !== cur.v) begin nerr++; $display("FAIL %s[%0d]: got %b want %b", cur.nm, i, obs, cur.v); end
         @(posedge clk); #1;
      end
`ifdef PIPE_CTRL_PERF_EN
      nchk++;
      if (stall_cnt - s0 !== 32'd1) begin nerr++; $display("FAIL stall_cnt: got %0d want 1", stall_cnt - s0); end
`endif
   endtask

   task automatic test_redirect;
      logic [3:0] stim [4];
      logic [9:0] e [4];
      stim = '{4'b1100, 4'b0000, 4'b0000, 4'b0000};
      e    = '{ev(C_RD, 0, 0), ev(C_FL, 1, 0), ev(C_FL, 1, 0), ev(C_RUN, 0, 0)};
      for (int i = 0; i < 4; i++) begin
         drive(stim[i], e[i], "redirect");
         cur = sb.pop_front(); nchk++;
         if (obs !== cur.v) begin nerr++; $display("FAIL %s[%0d]: got %b want %b", cur.nm, i, obs, cur.v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_stall;
      logic [3:0] stim [6];
      logic [9:0] e [6];
      // the redirect in cycle 2 arrives while frozen and must be ignored
      stim = '{4'b0010, 4'b0010, 4'b0110, 4'b0010, 4'b0011, 4'b0000};
      e    = '{ev(C_FRZ, 0, 0), ev(C_FRZ, 2, 0), ev(C_FRZ, 2, 0), ev(C_FRZ, 2, 0),
               ev(C_RUN, 2, 0), ev(C_RUN, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         drive(stim[i], e[i], "mem_stall");
         cur = sb.pop_front(); nchk++;
         if (obs !== cur.v) begin nerr++; $display("FAIL %s[%0d]: got %b want %b", cur.nm, i, obs, cur.v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] stim [7];
      logic [9:0] e [7];
      stim = '{4'b0100, 4'b0100, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
      e    = '{ev(C_RD, 0, 0), ev(C_RD, 1, 0), ev(C_FL, 1, 0), ev(C_FL, 1, 0),
               ev(C_LU, 0, 0), ev(C_LU, 0, 0), ev(C_RUN, 0, 0)};
      for (int i = 0; i < 7; i++) begin
         drive(stim[i], e[i], "back_to_back");
         cur = sb.pop_front(); nchk++;
         if (obs !== cur.v) begin nerr++; $display("FAIL %s[%0d]: got %b want %b", cur.nm, i, obs, cur.v); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_flush_mem;
      logic [3:0] stim [6];
      logic [9:0] e [6];
`ifdef PIPE_CTRL_PERF_EN
      logic [31:0] f0, m0;
      f0 = flush_cnt;
      m0 = memwait_cnt;
`endif
      stim = '{4'b0100, 4'b0010, 4'b0010, 4'b0011, 4'b0000, 4'b0000};
      e    = '{ev(C_RD, 0, 0), ev(C_FRZ, 1, 0), ev(C_FRZ, 2, 0), ev(C_FL, 2, 0),
               ev(C_FL, 1, 0), ev(C_RUN, 0, 0)};
      for (int i = 0; i < 6; i++) begin
         drive(stim[i], e[i], "flush_mem");
         cur = sb.pop_front(); nchk++;
         if (obs !== cur.v) begin nerr++; $display("FAIL %s[%0d]: got %b want %b", cur.nm, i, obs, cur.v); end
         @(posedge clk); #1;
      end
`ifdef PIPE_CTRL_PERF_EN
      nchk++;
      if (flush_cnt - f0 !== 32'd3) begin nerr++; $display("FAIL flush_cnt: got %0d want 3", flush_cnt - f0); end
      nchk++;
      if (memwait_cnt - m0 !== 32'd1) begin nerr++; $display("FAIL memwait_cnt: got %0d want 1", memwait_cnt - m0); end
`endif
   endtask

   task automatic test_timeout;
      logic [9:0] e;
      for (int i = 0; i < 18; i++) begin
         if (i == 0)       e = ev(C_FRZ, 0, 0);
         else if (i < 15)  e = ev(C_FRZ, 2, 0);
         else              e = ev(C_RST, 3, 1);
         drive(4'b0010, e, "timeout");
         cur = sb.pop_front(); nchk++;
         if (obs !== cur.v) begin nerr++; $display("FAIL %s[%0d]: got %b want %b", cur.nm, i, obs, cur.v); end
         @(posedge clk); #1;
      end
      // ERR is sticky even once memory answers
      drive(4'b0011, ev(C_RST, 3, 1), "timeout_sticky");
      cur = sb.pop_front(); nchk++;
      if (obs !== cur.v) begin nerr++; $display("FAIL %s: got %b want %b", cur.nm, obs, cur.v); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      drive(4'b0000, ev(C_RST, 0, 0), "timeout_rst");
      cur = sb.pop_front(); nchk++;
      if (obs !== cur.v) begin nerr++; $display("FAIL %s: got %b want %b", cur.nm, obs, cur.v); end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(4'b0000, ev(C_RUN, 0, 0), "timeout_clear");
      cur = sb.pop_front(); nchk++;
      if (obs !== cur.v) begin nerr++; $display("FAIL %s: got %b want %b", cur.nm, obs, cur.v); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset;
      test_load_use;
      test_redirect;
      test_mem_stall;
      test_back_to_back;
      test_flush_mem;
      test_timeout;
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
